adc_axis_packer: RTL and testbench

//  Downstream of the trigger-detect stage in ADC_Acq2DDR. Packs gated 16-bit ADC samples
//  (one per s_valid) into 64-bit AXI-Stream beats for the DDR DMA. Buffers beats in a sync

---
 rtl/acq_pkg.sv | 14 +
 rtl/axis_sync_fifo.sv | 50 +++++
 rtl/adc_axis_packer.sv | 153 +++++++++++++++
 tb/tb_adc_axis_packer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/acq_pkg.sv
// Shared widths and the round-tracking state type for the ADC acquisition path.
package acq_pkg;
  localparam int ADC_W  = 16;
  localparam int LANES  = 4;
  localparam int AXIS_W = 64;
  localparam int KEEP_W = 8;
  localparam int LANE_W = $clog2(LANES);
  localparam int LANE_KEEP = KEEP_W / LANES;

  typedef enum logic {
    RND_IDLE,
    RND_ACTIVE
  } round_state_t;
endpackage

// File: rtl/axis_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; exposes the head and the entry behind it so the
// consumer can refill its output register on the same edge it pops.
module axis_sync_fifo #(
  parameter int W     = 73,
  parameter int DEPTH = 16
) (
  input  logic                     Clk100M,
  input  logic                     Rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [W-1:0]             i_wrData,
  output logic [W-1:0]             o_head,
  output logic [W-1:0]             o_next,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW:0]   r_wrPtr;
  logic [AW:0]   r_rdPtr;
  logic          w_wrEn;
  logic          w_rdEn;
  logic [AW-1:0] w_rdNext;

  assign o_full   = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
  assign o_empty  = (r_wrPtr == r_rdPtr);
  assign o_count  = r_wrPtr - r_rdPtr;
  assign w_rdEn   = i_pop & ~o_empty;
  // A full FIFO still takes a write when the slot is freed by a pop on the same edge.
  assign w_wrEn   = i_push & (~o_full | w_rdEn);
  assign w_rdNext = r_rdPtr[AW-1:0] + AW'(1);
  assign o_head   = r_mem[r_rdPtr[AW-1:0]];
  assign o_next   = r_mem[w_rdNext];

  always_ff @(posedge Clk100M) begin
    if (w_wrEn) r_mem[r_wrPtr[AW-1:0]] <= i_wrData;
  end

  always_ff @(posedge Clk100M or negedge Rst_n) begin
    if (!Rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_wrEn) r_wrPtr <= r_wrPtr + (AW+1)'(1);
      if (w_rdEn) r_rdPtr <= r_rdPtr + (AW+1)'(1);
    end
  end
endmodule

// File: rtl/adc_axis_packer.sv
// Packs 16-bit ADC samples four to a 64-bit AXI-Stream beat, buffers beats against DMA
// backpressure, marks round ends with tlast and flags beats lost to a full buffer.
module adc_axis_packer
  import acq_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int ROUND_BEATS = 256
) (
  input  logic                               Clk100M,
  input  logic                               Rst_n,
  input  logic [ADC_W-1:0]                   ADC_Data,
  input  logic                               s_valid,
  input  logic                               s_last,
  output logic [AXIS_W-1:0]                  m_axis_tdata,
  output logic [KEEP_W-1:0]                  m_axis_tkeep,
  output logic                               m_axis_tlast,
  output logic                               m_axis_tvalid,
  input  logic                               m_axis_tready,
  input  logic                               Clear_Ovf,
  output logic                               Overflow,
  output logic                               Round_Done,
  output logic [$clog2(ROUND_BEATS+1)-1:0]   Beat_Cnt
);
  localparam int CNT_W = $clog2(ROUND_BEATS+1);
  localparam int FW    = AXIS_W + KEEP_W + 1;
  localparam int AW    = $clog2(FIFO_DEPTH);

  round_state_t      r_state, w_stateNext;
  logic [LANE_W-1:0] r_lane;
  logic [ADC_W-1:0]  r_hold [LANES];
  logic              r_pendLast;
  logic [AXIS_W-1:0] r_tdata;
  logic [KEEP_W-1:0] r_tkeep;
  logic              r_tlast;
  logic              r_tvalid;
  logic              r_ovf;
  logic              r_roundDone;
  logic [CNT_W-1:0]  r_beatCnt;

  logic [AXIS_W-1:0] w_word;
  logic [KEEP_W-1:0] w_keep;
  logic              w_wordLast;
  logic              w_pushReq;
  logic              w_pushOk;
  logic              w_drop;
  logic              w_hs;
  logic [FW-1:0]     w_fifoHead;
  logic [FW-1:0]     w_fifoNext;
  logic              w_fifoFull;
  logic              w_fifoEmpty;
  logic [AW:0]       w_fifoCount;

  assign w_pushReq  = s_valid & ((r_lane == LANE_W'(LANES-1)) | s_last);
  assign w_wordLast = s_last | r_pendLast;
  assign w_hs       = r_tvalid & m_axis_tready;
  // The output register plus the FIFO together hold FIFO_DEPTH beats, so a handshake frees a slot.
  assign w_pushOk   = w_pushReq & (~w_fifoFull | w_hs);
  assign w_drop     = w_pushReq & ~w_pushOk;

  always_comb begin
    w_word = '0;
    w_keep = '0;
    for (int i = 0; i < LANES; i++) begin
      if (i < int'(r_lane)) begin
        w_word[i*ADC_W +: ADC_W]         = r_hold[i];
        w_keep[i*LANE_KEEP +: LANE_KEEP] = '1;
      end else if (i == int'(r_lane)) begin
        w_word[i*ADC_W +: ADC_W]         = ADC_Data;
        w_keep[i*LANE_KEEP +: LANE_KEEP] = '1;
      end
    end
  end

  axis_sync_fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .Clk100M  (Clk100M),
    .Rst_n    (Rst_n),
    .i_push   (w_pushOk),
    .i_pop    (w_hs),
    .i_wrData ({w_wordLast, w_keep, w_word}),
    .o_head   (w_fifoHead),
    .o_next   (w_fifoNext),
    .o_full   (w_fifoFull),
    .o_empty  (w_fifoEmpty),
    .o_count  (w_fifoCount)
  );

  always_ff @(posedge Clk100M) begin
    if (s_valid) r_hold[r_lane] <= ADC_Data;
  end

  always_ff @(posedge Clk100M or negedge Rst_n) begin
    if (!Rst_n) begin
      r_lane     <= '0;
      r_pendLast <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      if (s_valid) r_lane <= w_pushReq ? '0 : r_lane + LANE_W'(1);
      if (w_pushOk) r_pendLast <= 1'b0;
      else if (w_drop && w_wordLast) r_pendLast <= 1'b1;
      if (w_drop) r_ovf <= 1'b1;
      else if (Clear_Ovf) r_ovf <= 1'b0;
    end
  end

  // Output register mirrors the FIFO head; on a handshake it jumps to the entry behind it.
  always_ff @(posedge Clk100M or negedge Rst_n) begin
    if (!Rst_n) begin
      r_tdata     <= '0;
      r_tkeep     <= '0;
      r_tlast     <= 1'b0;
      r_tvalid    <= 1'b0;
      r_roundDone <= 1'b0;
      r_beatCnt   <= '0;
    end else begin
      if (!r_tvalid) begin
        if (!w_fifoEmpty) begin
          {r_tlast, r_tkeep, r_tdata} <= w_fifoHead;
          r_tvalid <= 1'b1;
        end
      end else if (w_hs) begin
        if (w_fifoCount > (AW+1)'(1)) {r_tlast, r_tkeep, r_tdata} <= w_fifoNext;
        else r_tvalid <= 1'b0;
      end
      r_roundDone <= w_hs & r_tlast;
      if (w_hs) begin
        if (r_tlast) r_beatCnt <= '0;
        else if (r_beatCnt != CNT_W'(ROUND_BEATS)) r_beatCnt <= r_beatCnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge Clk100M or negedge Rst_n) begin
    if (!Rst_n) r_state <= RND_IDLE;
    else r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      RND_IDLE:   if (s_valid && !(w_pushReq && s_last)) w_stateNext = RND_ACTIVE;
      RND_ACTIVE: if (w_pushReq && s_last) w_stateNext = RND_IDLE;
      default:    w_stateNext = RND_IDLE;
    endcase
  end

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tkeep  = r_tkeep;
  assign m_axis_tlast  = r_tlast;
  assign m_axis_tvalid = r_tvalid;
  assign Overflow      = r_ovf;
  assign Round_Done    = r_roundDone;
  assign Beat_Cnt      = r_beatCnt;
endmodule

// File: tb/tb_adc_axis_packer.sv
// Randomized self-checking bench for adc_axis_packer against a sample-queue reference model.
module tb_adc_axis_packer;
  logic        Clk100M = 1'b0;
  logic        Rst_n = 1'b0;
  logic [15:0] ADC_Data = '0;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic        m_axis_tlast;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic        Clear_Ovf = 1'b0;
  logic        Overflow;
  logic        Round_Done;
  logic [8:0]  Beat_Cnt;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } beat_t;

  beat_t       expQ[$];
  beat_t       rxQ[$];
  logic [15:0] pendS[$];
  int          mOcc, mBeat, mDrop, rdPulses, stableViol;
  logic        mPend;
  logic        prevHold;
  logic [72:0] prevBeat;
  int          errors = 0;
  int          checks = 0;

  always #5 Clk100M = ~Clk100M;

  adc_axis_packer #(.FIFO_DEPTH(16), .ROUND_BEATS(256)) dut (
    .Clk100M       (Clk100M),
    .Rst_n         (Rst_n),
    .ADC_Data      (ADC_Data),
    .s_valid       (s_valid),
    .s_last        (s_last),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .Clear_Ovf     (Clear_Ovf),
    .Overflow      (Overflow),
    .Round_Done    (Round_Done),
    .Beat_Cnt      (Beat_Cnt)
  );

  function automatic logic [63:0] seqBeat(int base);
    return {16'(base+3), 16'(base+2), 16'(base+1), 16'(base)};
  endfunction

  task automatic applyReset();
    @(negedge Clk100M);
    Rst_n = 1'b0;
    s_valid = 1'b0; s_last = 1'b0; ADC_Data = '0; m_axis_tready = 1'b0; Clear_Ovf = 1'b0;
    expQ.delete(); rxQ.delete(); pendS.delete();
    mOcc = 0; mBeat = 0; mDrop = 0; rdPulses = 0; stableViol = 0; mPend = 1'b0;
    prevHold = 1'b0; prevBeat = '0;
    repeat (2) @(negedge Clk100M);
    Rst_n = 1'b1;
  endtask

  // One clock: observe the bus, drive the next inputs, and advance the reference model.
  task automatic step(input logic sv, input logic [15:0] d, input logic lst, input logic rdy);
    beat_t b;
    logic  hs;
    @(negedge Clk100M);
    if (Round_Done) rdPulses++;
    if (prevHold && (!m_axis_tvalid || {m_axis_tlast, m_axis_tkeep, m_axis_tdata} !== prevBeat))
      stableViol++;
    s_valid = sv; ADC_Data = d; s_last = lst; m_axis_tready = rdy;
    hs = m_axis_tvalid & rdy;
    if (hs) begin
      b.d = m_axis_tdata; b.k = m_axis_tkeep; b.l = m_axis_tlast;
      rxQ.push_back(b);
      if (rxQ.size() <= expQ.size()) begin
        if (expQ[rxQ.size()-1].l) mBeat = 0;
        else if (mBeat < 256) mBeat++;
      end
    end
    if (sv) begin
      pendS.push_back(d);
      if (pendS.size() == 4 || lst) begin
        b.d = '0; b.k = '0;
        for (int i = 0; i < pendS.size(); i++) begin
          b.d[16*i +: 16] = pendS[i];
          b.k[2*i +: 2] = 2'b11;
        end
        b.l = lst | mPend;
        pendS.delete();
        if (mOcc < 16 || hs) begin
          expQ.push_back(b); mOcc++; mPend = 1'b0;
        end else begin
          mDrop++;
          if (b.l) mPend = 1'b1;
        end
      end
    end
    if (hs) mOcc--;
    prevHold = m_axis_tvalid & ~rdy;
    prevBeat = {m_axis_tlast, m_axis_tkeep, m_axis_tdata};
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge Clk100M);
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_tvalid: got %b expected 0", m_axis_tvalid); end
    checks++; if (m_axis_tdata !== 64'h0) begin errors++; $display("[TB] FAIL reset_tdata: got %h expected 0", m_axis_tdata); end
    checks++; if (m_axis_tkeep !== 8'h0) begin errors++; $display("[TB] FAIL reset_tkeep: got %h expected 0", m_axis_tkeep); end
    checks++; if (m_axis_tlast !== 1'b0) begin errors++; $display("[TB] FAIL reset_tlast: got %b expected 0", m_axis_tlast); end
    checks++; if (Overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow: got %b expected 0", Overflow); end
    checks++; if (Round_Done !== 1'b0) begin errors++; $display("[TB] FAIL reset_round_done: got %b expected 0", Round_Done); end
    checks++; if (Beat_Cnt !== 9'd0) begin errors++; $display("[TB] FAIL reset_beat_cnt: got %0d expected 0", Beat_Cnt); end
  endtask

  task automatic test_full_round();
    int bad;
    applyReset();
    for (int i = 0; i < 1024; i++) step(1'b1, 16'(i), i == 1023, 1'b1);
    drain(8);
    checks++; if (rxQ.size() != 256) begin errors++; $display("[TB] FAIL full_round_beats: got %0d expected 256", rxQ.size()); end
    if (rxQ.size() > 0) begin
      checks++;
      if (rxQ[0].d !== 64'h0003_0002_0001_0000 || rxQ[0].k !== 8'hFF) begin
        errors++; $display("[TB] FAIL full_round_beat0: got %h/%h expected 0003000200010000/ff", rxQ[0].d, rxQ[0].k);
      end
    end
    bad = 0;
    for (int i = 0; i < rxQ.size(); i++)
      if (rxQ[i].d !== seqBeat(4*i) || rxQ[i].k !== 8'hFF || rxQ[i].l !== (i == 255)) bad++;
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL full_round_content: got %0d bad beats expected 0", bad); end
    checks++; if (rdPulses != 1) begin errors++; $display("[TB] FAIL full_round_done: got %0d pulses expected 1", rdPulses); end
    checks++; if (Beat_Cnt !== 9'd0) begin errors++; $display("[TB] FAIL full_round_beat_cnt: got %0d expected 0", Beat_Cnt); end
  endtask

  task automatic test_short_round();
    logic [15:0] s [6];
    applyReset();
    for (int i = 0; i < 6; i++) s[i] = 16'($urandom);
    for (int i = 0; i < 6; i++) step(1'b1, s[i], i == 5, 1'b1);
    drain(6);
    checks++; if (rxQ.size() != 2) begin errors++; $display("[TB] FAIL short_beats: got %0d expected 2", rxQ.size()); end
    if (rxQ.size() >= 2) begin
      checks++; if (rxQ[0].d !== {s[3], s[2], s[1], s[0]} || rxQ[0].k !== 8'hFF || rxQ[0].l !== 1'b0) begin
        errors++; $display("[TB] FAIL short_beat0: got %h/%h/%b expected %h/ff/0", rxQ[0].d, rxQ[0].k, rxQ[0].l, {s[3], s[2], s[1], s[0]});
      end
      checks++; if (rxQ[1].k !== 8'h0F) begin errors++; $display("[TB] FAIL short_keep: got %h expected 0f", rxQ[1].k); end
      checks++; if (rxQ[1].l !== 1'b1) begin errors++; $display("[TB] FAIL short_tlast: got %b expected 1", rxQ[1].l); end
      checks++; if (rxQ[1].d !== {32'h0, s[5], s[4]}) begin
        errors++; $display("[TB] FAIL short_data: got %h expected %h", rxQ[1].d, {32'h0, s[5], s[4]});
      end
    end
  endtask

  task automatic test_overflow();
    int bad;
    applyReset();
    for (int i = 0; i < 100; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b0);
    checks++; if (Overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_set: got %b expected 1", Overflow); end
    checks++; if (m_axis_tvalid !== 1'b1) begin errors++; $display("[TB] FAIL ovf_tvalid: got %b expected 1", m_axis_tvalid); end
    // A last-carrying beat lost here must push tlast onto the next surviving beat.
    for (int i = 100; i < 104; i++) step(1'b1, 16'(i), i == 103, 1'b0);
    drain(40);
    checks++; if (rxQ.size() != 16) begin errors++; $display("[TB] FAIL ovf_buffered: got %0d expected 16", rxQ.size()); end
    bad = 0;
    for (int i = 0; i < rxQ.size(); i++) if (rxQ[i].d !== seqBeat(4*i) || rxQ[i].l !== 1'b0) bad++;
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL ovf_order: got %0d bad beats expected 0", bad); end
    checks++; if (Overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_sticky: got %b expected 1", Overflow); end
    @(negedge Clk100M); Clear_Ovf = 1'b1;
    @(negedge Clk100M); Clear_Ovf = 1'b0;
    checks++; if (Overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_clear: got %b expected 0", Overflow); end
    for (int i = 200; i < 204; i++) step(1'b1, 16'(i), 1'b0, 1'b1);
    drain(6);
    checks++; if (rxQ.size() != 17) begin errors++; $display("[TB] FAIL pend_beats: got %0d expected 17", rxQ.size()); end
    if (rxQ.size() >= 17) begin
      checks++; if (rxQ[16].l !== 1'b1 || rxQ[16].d !== seqBeat(200)) begin
        errors++; $display("[TB] FAIL pend_last: got %h/%b expected %h/1", rxQ[16].d, rxQ[16].l, seqBeat(200));
      end
    end
    checks++; if (Beat_Cnt !== 9'd0) begin errors++; $display("[TB] FAIL pend_beat_cnt: got %0d expected 0", Beat_Cnt); end
  endtask

  task automatic test_full_accept();
    applyReset();
    for (int i = 0; i < 67; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
    step(1'b1, 16'd67, 1'b0, 1'b1);
    drain(30);
    checks++; if (Overflow !== 1'b0) begin errors++; $display("[TB] FAIL full_accept_ovf: got %b expected 0", Overflow); end
    checks++; if (rxQ.size() != 17) begin errors++; $display("[TB] FAIL full_accept_beats: got %0d expected 17", rxQ.size()); end
    if (rxQ.size() >= 17) begin
      checks++; if (rxQ[16].d !== seqBeat(64)) begin
        errors++; $display("[TB] FAIL full_accept_data: got %h expected %h", rxQ[16].d, seqBeat(64));
      end
    end
  endtask

  task automatic test_saturate();
    applyReset();
    for (int i = 0; i < 1100; i++) step(1'b1, 16'(i), 1'b0, 1'b1);
    drain(8);
    checks++; if (rxQ.size() != 275) begin errors++; $display("[TB] FAIL sat_beats: got %0d expected 275", rxQ.size()); end
    checks++; if (Beat_Cnt !== 9'd256) begin errors++; $display("[TB] FAIL sat_beat_cnt: got %0d expected 256", Beat_Cnt); end
  endtask

  task automatic test_random();
    int bad;
    int len;
    int sent;
    logic sv;
    applyReset();
    for (int r = 0; r < 4; r++) begin
      len = $urandom_range(9, 150);
      sent = 0;
      while (sent < len) begin
        sv = 1'($urandom_range(0, 1));
        if (sv) sent++;
        step(sv, 16'($urandom), sv && (sent == len), 1'($urandom_range(0, 1)));
      end
    end
    for (int i = 0; i < 300; i++) step(1'b0, 16'h0, 1'b0, 1'($urandom_range(0, 1)));
    drain(20);
    checks++; if (rxQ.size() != expQ.size()) begin errors++; $display("[TB] FAIL rand_count: got %0d expected %0d", rxQ.size(), expQ.size()); end
    bad = 0;
    for (int i = 0; i < rxQ.size() && i < expQ.size(); i++)
      if (rxQ[i].d !== expQ[i].d || rxQ[i].k !== expQ[i].k || rxQ[i].l !== expQ[i].l) bad++;
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL rand_content: got %0d bad beats expected 0", bad); end
    checks++; if (stableViol != 0) begin errors++; $display("[TB] FAIL rand_stable: got %0d violations expected 0", stableViol); end
    checks++; if (rdPulses != 4) begin errors++; $display("[TB] FAIL rand_rounds: got %0d expected 4", rdPulses); end
    checks++; if (Overflow !== (mDrop != 0)) begin errors++; $display("[TB] FAIL rand_ovf: got %b expected %b", Overflow, mDrop != 0); end
    checks++; if (Beat_Cnt !== 9'(mBeat)) begin errors++; $display("[TB] FAIL rand_beat_cnt: got %0d expected %0d", Beat_Cnt, mBeat); end
  endtask

  task automatic test_reset_midround();
    applyReset();
    for (int i = 0; i < 10; i++) step(1'b1, 16'(16'h5000 + i), 1'b0, 1'b0);
    applyReset();
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL midreset_tvalid: got %b expected 0", m_axis_tvalid); end
    for (int i = 0; i < 8; i++) step(1'b1, 16'(16'hA000 + i), i == 7, 1'b1);
    drain(8);
    checks++; if (rxQ.size() != 2) begin errors++; $display("[TB] FAIL midreset_beats: got %0d expected 2", rxQ.size()); end
    if (rxQ.size() >= 2) begin
      checks++; if (rxQ[0].d !== seqBeat(32'hA000) || rxQ[0].l !== 1'b0) begin
        errors++; $display("[TB] FAIL midreset_first: got %h/%b expected %h/0", rxQ[0].d, rxQ[0].l, seqBeat(32'hA000));
      end
      checks++; if (rxQ[1].l !== 1'b1) begin errors++; $display("[TB] FAIL midreset_last: got %b expected 1", rxQ[1].l); end
    end
    checks++; if (rdPulses != 1) begin errors++; $display("[TB] FAIL midreset_done: got %0d expected 1", rdPulses); end
  endtask

  initial begin
    test_reset();
    test_full_round();
    test_short_round();
    test_overflow();
    test_full_accept();
    test_saturate();
    test_random();
    test_reset_midround();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
